// File: rtl/tff_count_sequencer_pkg.sv
// tff_count_sequencer_pkg: shared FSM state type and direction encodings
// Contents:
//   seq_state_t  IDLE / RUN / DONE sequencer states
//   DIR_UP       direction code for counting up
//   DIR_DOWN     direction code for counting down
package tff_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_count_sequencer_if.sv
// tff_count_sequencer_if: control/status bundle between control logic and the T-FF sequencer
// Signals:
//   start, dir, limit     begin a count run toward limit, up (1) or down (0)
//   load_en, load_val     one-cycle parallel load of the bank
//   pause                 freeze an active run
//   q, toggle_out         bank state and the toggle vector applied this cycle
//   busy, done            run in progress / one-cycle completion pulse
// Modports: master = control side, slave = sequencer
interface tff_count_sequencer_if #(parameter int WIDTH = 4);

    logic             start;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             load_en;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] toggle_out;
    logic             busy;
    logic             done;

    modport master (
        output start, dir, limit, load_en, load_val, pause,
        input  q, toggle_out, busy, done
    );

    modport slave (
        input  start, dir, limit, load_en, load_val, pause,
        output q, toggle_out, busy, done
    );

endinterface

// File: rtl/tff_count_sequencer_cell.sv
// tff_cell: single toggle flip-flop of the sequencer bank
// Ports:
//   clk  in   clock, posedge
//   rst  in   synchronous active-low reset, clears q
//   t    in   toggle enable
//   q    out  stored bit
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk)
        q <= !rst ? 1'b0 : q ^ t;

endmodule

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: drives a T-FF bank to count toward a limit or load a value
// Ports:
//   clk  in      clock, posedge
//   rst  in      synchronous active-low reset; aborts a run without done
//   bus  slave   start/dir/limit, load_en/load_val, pause in;
//                q, toggle_out, busy, done out
module tff_count_sequencer
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    tff_count_sequencer_if.slave bus
);

    seq_state_t       state;
    logic             dir_r;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    // A bit toggles on an increment when all lower bits are 1,
    // and on a decrement when all lower bits are 0.
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar j = 1; j < WIDTH; j++) begin : g_carry
        assign up_t[j] = &bus.q[j-1:0];
        assign dn_t[j] = ~|bus.q[j-1:0];
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (bus.toggle_out[j]),
            .q   (bus.q[j])
        );
    end

    assign bus.busy = rst && state == RUN;

    // Loading toggles exactly the bits where q differs from load_val.
    always_comb
        bus.toggle_out = !rst                                      ? '0 :
                         (state == IDLE && bus.load_en)            ? bus.q ^ bus.load_val :
                         (state == RUN && !bus.pause && bus.q != lim_r) ? (dir_r == DIR_UP ? up_t : dn_t) :
                                                                     '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            dir_r    <= DIR_DOWN;
            lim_r    <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE:
                    if (!bus.load_en && bus.start) begin
                        state <= RUN;
                        dir_r <= bus.dir;
                        lim_r <= bus.limit;
                    end
                RUN:
                    if (!bus.pause && bus.q == lim_r) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                default:
                    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: randomized scoreboard bench for tff_count_sequencer (WIDTH=4)
module tb_tff_count_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tff_count_sequencer_if #(.WIDTH(4)) bus ();

    tff_count_sequencer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         d;
        logic [3:0] q;
        int         cyc;
        int         steps;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mq = 4'd0;
    int         bc = 0;
    int         nt = 0;

    task automatic chk(input string n, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", n, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of RUN cycles: n stepping cycles plus the terminal-compare cycle,
    // with every paused cycle inserted wherever the mask places it.
    function automatic int run_cycles(input logic [63:0] pm, input int n);
        int unp = 0;
        for (int t = 0; t < 200; t++) begin
            if (!(t < 64 && pm[t])) unp++;
            if (unp == n + 1) return t + 1;
        end
        return -1;
    endfunction

    // Monitor: per-cycle toggle sanity during runs, scoreboard pop on done.
    always @(negedge clk) begin
        logic [3:0] nx;
        exp_t e;
        if (!rst) begin
            bc = 0;
            nt = 0;
        end else begin
            if (bus.busy) begin
                bc++;
                if (bus.toggle_out != 4'd0 && sb.size() > 0) begin
                    nt++;
                    nx = sb[0].d ? bus.q + 4'd1 : bus.q - 4'd1;
                    chk("step_toggle", bus.toggle_out, bus.q ^ nx);
                end
            end
            if (bus.done) begin
                chk("done_expected", sb.size() > 0, 1);
                chk("done_busy_low", bus.busy, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("run_final_q", bus.q, e.q);
                    chk("run_cycles", bc, e.cyc);
                    chk("run_steps", nt, e.steps);
                end
                bc = 0;
                nt = 0;
            end
        end
    end

    task automatic do_load(input logic [3:0] v, input bit st);
        bus.load_en  = 1'b1;
        bus.load_val = v;
        bus.start    = st;
        bus.dir      = 1'($urandom);
        bus.limit    = 4'($urandom);
        #1;
        chk("load_toggle", bus.toggle_out, mq ^ v);
        tick();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        chk("load_q", bus.q, v);
        chk("load_busy", bus.busy, 0);
        mq = v;
    endtask

    task automatic do_run(input bit d, input logic [3:0] lim, input logic [63:0] pm);
        exp_t e;
        int   c;
        logic [3:0] n;
        n = d ? lim - mq : mq - lim;
        e.d = d;
        e.q = lim;
        e.steps = int'(n);
        e.cyc = run_cycles(pm, int'(n));
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.dir     = d;
        bus.limit   = lim;
        bus.load_en = 1'b0;
        bus.pause   = 1'b0;
        tick();
        for (c = 0; c < 200 && !bus.done; c++) begin
            bus.start    = 1'($urandom);
            bus.load_en  = 1'($urandom);
            bus.load_val = 4'($urandom);
            bus.dir      = 1'($urandom);
            bus.limit    = 4'($urandom);
            bus.pause    = (c < 64) ? pm[c] : 1'b0;
            tick();
        end
        chk("run_timeout", c < 200, 1);
        bus.pause = 1'($urandom);
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        bus.pause   = 1'b0;
        chk("idle_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
        mq = lim;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pm;
        bus.start    = 1'b0;
        bus.dir      = 1'b0;
        bus.limit    = 4'd0;
        bus.load_en  = 1'b0;
        bus.load_val = 4'd0;
        bus.pause    = 1'b0;
        tick();
        tick();
        chk("reset_q", bus.q, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_toggle", bus.toggle_out, 0);
        rst = 1'b1;
        tick();

        do_load(4'b1010, 1'b0);
        do_load(4'b0000, 1'b0);
        do_run(1'b1, 4'd5, 64'd0);

        do_load(4'b0001, 1'b0);
        do_run(1'b0, 4'd14, 64'd0);

        do_load(4'b0000, 1'b0);
        do_run(1'b1, 4'd5, 64'b11000);

        do_run(1'b1, 4'd5, 64'd0);

        // Abort a run at q=3 with reset; no done may follow.
        do_load(4'b0000, 1'b0);
        begin
            exp_t e;
            e.d = 1'b1;
            e.q = 4'd5;
            e.cyc = 6;
            e.steps = 5;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        bus.dir   = 1'b1;
        bus.limit = 4'd5;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("abort_pre_q", bus.q, 3);
        chk("abort_pre_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("abort_comb_busy", bus.busy, 0);
        chk("abort_comb_toggle", bus.toggle_out, 0);
        tick();
        tick();
        chk("abort_q", bus.q, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_toggle", bus.toggle_out, 0);
        sb.delete();
        rst = 1'b1;
        mq = 4'd0;
        tick();

        do_load(4'b0111, 1'b1);
        repeat (4) tick();
        chk("load_over_start_q", bus.q, 7);
        chk("load_over_start_busy", bus.busy, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load(4'($urandom), 1'($urandom));
            else begin
                pm = '0;
                for (int b = 0; b < 64; b++)
                    pm[b] = ($urandom_range(0, 3) == 0);
                do_run(1'($urandom), 4'($urandom), pm);
            end
        end

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
